// File: rtl/arm_rf_wr_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back always wins; multi-cycle
// results wait in a small FIFO, drain in idle cycles, and a starvation counter forces a stall.
module arm_rf_wr_arbiter #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic [31:0]              WB_data,
    input  logic                     WB_rd_we,
    input  logic [3:0]               WB_des_reg_num,
    input  logic                     mc_valid,
    output logic                     mc_ready,
    input  logic [3:0]               mc_reg_num,
    input  logic [31:0]              mc_data,
    output logic                     rf_wr_en,
    output logic [3:0]               rf_wr_num,
    output logic [31:0]              rf_wr_data,
    output logic                     pipe_stall,
    output logic [15:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     collision_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [3:0]    r_fifo_num  [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [SW-1:0] r_starve;
    logic          r_mc_ready;
    logic          r_collision;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_stall;
    logic [CW-1:0] w_next_count;
    logic [SW-1:0] w_next_starve;
    logic [15:0]   w_pending;

    assign w_empty      = (r_count == '0);
    assign w_push       = mc_valid && r_mc_ready;
    assign w_pop        = !WB_rd_we && !w_empty;
    assign w_next_count = r_count + CW'(w_push) - CW'(w_pop);
    assign w_stall      = (r_starve == SW'(STARVE_LIMIT));

    // Port grant: pipeline first, then FIFO head; address/data follow WB when idle.
    always_comb begin
        rf_wr_en   = WB_rd_we;
        rf_wr_num  = WB_des_reg_num;
        rf_wr_data = WB_data;
        if (w_pop) begin
            rf_wr_en   = 1'b1;
            rf_wr_num  = r_fifo_num[r_rd_ptr];
            rf_wr_data = r_fifo_data[r_rd_ptr];
        end
    end

    // Pending-register mask over the valid FIFO window only.
    always_comb begin
        w_pending = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < r_count) begin
                w_pending[r_fifo_num[r_rd_ptr + AW'(k)]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_next_starve = r_starve;
        if (w_empty || w_pop) begin
            w_next_starve = '0;
        end else if (WB_rd_we && !w_stall) begin
            w_next_starve = r_starve + SW'(1);
        end
    end

    // Payload storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_num[r_wr_ptr]  <= mc_reg_num;
            r_fifo_data[r_wr_ptr] <= mc_data;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_mc_ready  <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count    <= w_next_count;
            r_starve   <= w_next_starve;
            r_mc_ready <= (w_next_count < CW'(DEPTH));
            if (WB_rd_we && w_stall) r_collision <= 1'b1;
        end
    end

    assign mc_ready      = r_mc_ready;
    assign pipe_stall    = w_stall;
    assign pending_mask  = w_pending;
    assign fifo_count    = r_count;
    assign collision_err = r_collision;

endmodule

// File: tb/tb_arm_rf_wr_arbiter.sv
// Bench for arm_rf_wr_arbiter: directed cycles plus a scoreboard of queued mc writes
// that are matched against every FIFO-sourced register-file write.
module tb_arm_rf_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] WB_data;
    logic        WB_rd_we;
    logic [3:0]  WB_des_reg_num;
    logic        mc_valid;
    logic        mc_ready;
    logic [3:0]  mc_reg_num;
    logic [31:0] mc_data;
    logic        rf_wr_en;
    logic [3:0]  rf_wr_num;
    logic [31:0] rf_wr_data;
    logic        pipe_stall;
    logic [15:0] pending_mask;
    logic [2:0]  fifo_count;
    logic        collision_err;

    int n_vec = 0;
    int n_err = 0;
    logic [35:0] exp_q[$];

    arm_rf_wr_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst_b(rst_b),
        .WB_data(WB_data), .WB_rd_we(WB_rd_we), .WB_des_reg_num(WB_des_reg_num),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_reg_num(mc_reg_num), .mc_data(mc_data),
        .rf_wr_en(rf_wr_en), .rf_wr_num(rf_wr_num), .rf_wr_data(rf_wr_data),
        .pipe_stall(pipe_stall), .pending_mask(pending_mask), .fifo_count(fifo_count),
        .collision_err(collision_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard: at mid-cycle, match FIFO-sourced writes first, then record a new transfer.
    always @(negedge clk) begin
        if (!rst_b) begin
            exp_q.delete();
        end else begin
            if (pipe_stall) check_val("stall_nonempty", 32'(fifo_count == 3'd0), 32'd0);
            if (WB_rd_we) begin
                check_val("wb_num", 32'(rf_wr_num), 32'(WB_des_reg_num));
                check_val("wb_data", rf_wr_data, WB_data);
            end else if (rf_wr_en) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_wr", 32'(rf_wr_num), 32'hFFFF_FFFF);
                end else begin
                    logic [35:0] e;
                    e = exp_q.pop_front();
                    check_val("sb_num", 32'(rf_wr_num), 32'(e[35:32]));
                    check_val("sb_data", rf_wr_data, e[31:0]);
                end
            end
            if (mc_valid && mc_ready) exp_q.push_back({mc_reg_num, mc_data});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b = 1'b0; WB_data = 32'h0; WB_rd_we = 1'b0; WB_des_reg_num = 4'd0;
        mc_valid = 1'b0; mc_reg_num = 4'd0; mc_data = 32'h0;

        // Reset: pass-through and cleared state
        #2;
        WB_rd_we = 1'b1; WB_des_reg_num = 4'd7; WB_data = 32'h7777_0007;
        settle();
        check_val("rst_wren", 32'(rf_wr_en), 32'd1);
        check_val("rst_num", 32'(rf_wr_num), 32'd7);
        check_val("rst_mask", 32'(pending_mask), 32'h0);
        check_val("rst_count", 32'(fifo_count), 32'd0);
        check_val("rst_stall", 32'(pipe_stall), 32'd0);
        check_val("rst_ready", 32'(mc_ready), 32'd0);
        WB_rd_we = 1'b0;
        settle();
        check_val("rst_wren0", 32'(rf_wr_en), 32'd0);
        tick(); tick();
        rst_b = 1'b1;
        settle();
        check_val("rel_c0_ready", 32'(mc_ready), 32'd0);
        tick();
        check_val("rel_c1_ready", 32'(mc_ready), 32'd1);
        check_val("rel_count", 32'(fifo_count), 32'd0);
        check_val("rel_mask", 32'(pending_mask), 32'h0);

        // Idle drain
        mc_valid = 1'b1; mc_reg_num = 4'd3; mc_data = 32'hDEAD_BEEF;
        tick();
        mc_valid = 1'b0;
        settle();
        check_val("drain_en", 32'(rf_wr_en), 32'd1);
        check_val("drain_num", 32'(rf_wr_num), 32'd3);
        check_val("drain_data", rf_wr_data, 32'hDEAD_BEEF);
        check_val("drain_mask", 32'(pending_mask), 32'h0008);
        tick();
        check_val("drain_mask0", 32'(pending_mask), 32'h0);
        check_val("drain_cnt0", 32'(fifo_count), 32'd0);

        // Priority and ordering
        WB_rd_we = 1'b1; WB_des_reg_num = 4'd1; WB_data = 32'h1111_0000;
        mc_valid = 1'b1; mc_reg_num = 4'd4; mc_data = 32'd1;
        tick();
        WB_data = 32'h1111_0001; mc_reg_num = 4'd5; mc_data = 32'd2;
        tick();
        WB_data = 32'h1111_0002; mc_valid = 1'b0;
        settle();
        check_val("prio_num", 32'(rf_wr_num), 32'd1);
        check_val("prio_mask", 32'(pending_mask), 32'h0030);
        check_val("prio_cnt", 32'(fifo_count), 32'd2);
        tick();
        WB_rd_we = 1'b0;
        settle();
        check_val("ord0_num", 32'(rf_wr_num), 32'd4);
        check_val("ord0_data", rf_wr_data, 32'd1);
        check_val("ord0_mask", 32'(pending_mask), 32'h0030);
        tick();
        check_val("ord1_num", 32'(rf_wr_num), 32'd5);
        check_val("ord1_data", rf_wr_data, 32'd2);
        check_val("ord1_mask", 32'(pending_mask), 32'h0020);
        tick();
        check_val("ord_cnt0", 32'(fifo_count), 32'd0);

        // Full FIFO
        WB_rd_we = 1'b1; WB_des_reg_num = 4'd0; mc_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mc_reg_num = 4'(8 + i); mc_data = 32'h100 + 32'(i); WB_data = 32'(i);
            settle();
            check_val("fill_ready", 32'(mc_ready), 32'd1);
            tick();
        end
        mc_reg_num = 4'd12; mc_data = 32'hBAD0_0012;
        settle();
        check_val("full_cnt", 32'(fifo_count), 32'd4);
        check_val("full_ready", 32'(mc_ready), 32'd0);
        check_val("full_mask", 32'(pending_mask), 32'h0F00);
        tick();
        check_val("full_cnt_hold", 32'(fifo_count), 32'd4);
        WB_rd_we = 1'b0;
        tick();
        mc_valid = 1'b0;
        check_val("pop_ready", 32'(mc_ready), 32'd1);
        check_val("pop_cnt", 32'(fifo_count), 32'd3);
        tick(); tick(); tick();
        check_val("full_drained", 32'(fifo_count), 32'd0);

        // Starvation
        WB_rd_we = 1'b1; mc_valid = 1'b1; mc_reg_num = 4'd6; mc_data = 32'hCAFE_0006;
        tick();
        mc_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            check_val("starve_low", 32'(pipe_stall), 32'd0);
            WB_data = 32'h6000 + 32'(i);
            tick();
        end
        check_val("starve_high", 32'(pipe_stall), 32'd1);
        WB_rd_we = 1'b0;
        settle();
        check_val("starve_wr_num", 32'(rf_wr_num), 32'd6);
        tick();
        check_val("starve_clr", 32'(pipe_stall), 32'd0);
        check_val("starve_cnt0", 32'(fifo_count), 32'd0);

        // Collision
        WB_rd_we = 1'b1; mc_valid = 1'b1; mc_reg_num = 4'd2; mc_data = 32'h2222_2222;
        tick();
        mc_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check_val("coll_stall", 32'(pipe_stall), 32'd1);
        check_val("coll_pre", 32'(collision_err), 32'd0);
        tick();
        check_val("coll_set", 32'(collision_err), 32'd1);
        check_val("coll_sat", 32'(pipe_stall), 32'd1);
        WB_rd_we = 1'b0;
        tick(); tick();
        check_val("coll_sticky", 32'(collision_err), 32'd1);
        check_val("coll_stall0", 32'(pipe_stall), 32'd0);

        // Reset mid-queue discards entries
        WB_rd_we = 1'b1; mc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mc_reg_num = 4'(13 + i); mc_data = 32'hE000 + 32'(i);
            tick();
        end
        mc_valid = 1'b0;
        check_val("mq_cnt", 32'(fifo_count), 32'd3);
        check_val("mq_mask", 32'(pending_mask), 32'hE000);
        WB_rd_we = 1'b0;
        rst_b = 1'b0;
        settle();
        check_val("mq_rst_cnt", 32'(fifo_count), 32'd0);
        check_val("mq_rst_coll", 32'(collision_err), 32'd0);
        check_val("mq_rst_mask", 32'(pending_mask), 32'h0);
        check_val("mq_rst_wren", 32'(rf_wr_en), 32'd0);
        tick(); tick();
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("post_rst_idle", 32'(rf_wr_en), 32'd0);
        end
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arm_rf_wr_arbiter.md
Name: arm_rf_wr_arbiter

Overview:
- Owns the single register-file write port and shares it between the pipeline write-back path (WB_data / WB_rd_we / WB_des_reg_num from the WB stage) and a multi-cycle requester (multiply-accumulate / load-multiple unit).
- Pipeline writes always have priority.
- Multi-cycle results are queued in a small FIFO and drained in free cycles.
- A starvation counter forces a one-cycle pipeline stall so queued writes cannot wait forever. A pending-register mask feeds the hazard unit for RAW/WAW interlock.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- STARVE_LIMIT, 8: consecutive cycles a non-empty FIFO may be blocked before pipe_stall is raised; >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  asynchronous, active-low reset.
- WB_data  in  32  pipeline write-back data.
- WB_rd_we  in  1  pipeline write enable.
- WB_des_reg_num  in  4  pipeline destination register.
- mc_valid  in  1  multi-cycle unit offers a write.
- mc_ready  out  1  FIFO accepts; a transfer occurs when mc_valid && mc_ready.
- mc_reg_num  in  4  multi-cycle destination register.
- mc_data  in  32  multi-cycle write data.
- rf_wr_en  out  1  register-file write enable.
- rf_wr_num  out  4  register-file write address.
- rf_wr_data  out  32  register-file write data.
- pipe_stall  out  1  request to hazard unit: bubble WB next cycle.
- pending_mask  out  16  bit r set iff any valid FIFO entry targets register r.
- fifo_count  out  $clog2(DEPTH)+1  number of valid entries.
- collision_err  out  1  sticky: pipeline wrote during a pipe_stall cycle.

Behaviour:
- Reset (rst_b low, asynchronous): FIFO empty, pointers 0, starve_cnt 0, mc_ready 0, collision_err 0.
  - Combinational outputs during reset: pending_mask 0, fifo_count 0, pipe_stall 0.
  - rf_* pass WB inputs through (rf_wr_en = WB_rd_we).
  - Reset mid-operation discards all queued writes; no rf write is issued for them.
- Enqueue: on a rising edge with mc_valid && mc_ready, {mc_reg_num, mc_data} is written at the tail.
  - mc_ready is a flop; its next value is (next_count < DEPTH). It is 1 on the first edge after reset release.
  - When full, mc_ready is 0 even if a pop occurs that cycle. There is no simultaneous push-when-full.
- Port grant (combinational, same cycle):
  - If WB_rd_we = 1: rf_* = WB inputs, and the FIFO is not popped.
  - Else if FIFO non-empty: rf_wr_en = 1, rf_* = head entry, and the head is popped on the edge.
  - Else: rf_wr_en = 0; rf_wr_num and rf_wr_data follow WB inputs (don't-care).
- Minimum latency from mc transfer to rf write is 1 cycle. There is no bypass.
- Push and pop may occur in the same edge; count is unchanged.
- FIFO ordering is strict; entries are never reordered. Duplicate register numbers are allowed.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- pending_mask is the OR of the one-hot decode of reg_num over valid entries. It is derived from registered state only; an entry is removed from the mask on the edge that pops it.
- starve_cnt (saturating at STARVE_LIMIT), updated per edge:
  - cleared if the FIFO is empty or a pop occurs;
  - otherwise incremented when the FIFO is non-empty and WB_rd_we = 1.
  - pipe_stall = (starve_cnt == STARVE_LIMIT).
- The hazard unit guarantees WB_rd_we = 0 in the cycle after it sees pipe_stall, which is the cycle in which pipe_stall is still high.
  - If WB_rd_we = 1 while pipe_stall = 1, the pipeline still wins, collision_err sets (sticky until reset), and the counter stays saturated.
- pipe_stall is never asserted while the FIFO is empty.

Test Plan:
- Reset release with no traffic: cycle 0 after rst_b rises mc_ready = 0, cycle 1 mc_ready = 1, and fifo_count = 0, pending_mask = 16'h0000, rf_wr_en follows WB_rd_we.
- Idle drain: WB_rd_we = 0, push {r3, 32'hDEAD_BEEF}. Next cycle rf_wr_en = 1, rf_wr_num = 3, rf_wr_data = 32'hDEADBEEF, pending_mask = 16'h0008. Following cycle pending_mask = 0, fifo_count = 0.
- Priority and order: WB_rd_we = 1 to r1 for 3 cycles while pushing r4 = 1, r5 = 2. rf writes r1 ×3 (pipeline data), then r4 = 1, then r5 = 2 once WB_rd_we drops. pending_mask = 16'h0030 while both are queued.
- Full FIFO: WB_rd_we held 1, push DEPTH = 4 entries. fifo_count = 4, mc_ready = 0, and a fifth mc_valid is not accepted. After one pop cycle, mc_ready returns to 1 the following cycle.
- Starvation: one queued entry, WB_rd_we = 1 continuously. pipe_stall rises after 8 blocked cycles. Drop WB_rd_we that cycle: entry written, pipe_stall = 0 next cycle, starve_cnt = 0.
- Collision and reset: keep WB_rd_we = 1 during pipe_stall, so collision_err = 1 and stays 1. Assert rst_b low mid-queue with 3 entries: fifo_count = 0, collision_err = 0 immediately, and no rf write is issued for the discarded entries.
